// File: rtl/mux_bus_arbiter_pkg.sv
// mux_bus_arbiter_pkg: state encodings, bus width and default hold limit shared by the arbiter.
package mux_bus_arbiter_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_GNT_A = 2'd1, ST_GNT_B = 2'd2} state_t;
  localparam int BUS_W = 4;
  localparam int HOLD_MAX_DEF = 4;
endpackage

// File: rtl/mux_bus_arbiter_mux2x1.sv
// mux2x1: gate-level W-bit 2:1 mux, s = 0 passes a.
module mux2x1 #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         s,
  output logic [W-1:0] y
);
  assign y = (a & {W{~s}}) | (b & {W{s}});
endmodule

// File: rtl/mux_bus_arbiter.sv
// mux_bus_arbiter: two-requester round-robin arbiter steering a 2:1 mux onto a registered bus.
// Optional hold limit enabled by MUX_BUS_ARB_HOLD_LIMIT_EN.
module mux_bus_arbiter
  import mux_bus_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [BUS_W-1:0] data_a,
  input  logic [BUS_W-1:0] data_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic [BUS_W-1:0] bus_out,
  output logic             bus_valid
);
  state_t state_q, state_d;
  logic last_q, last_d;
  logic [BUS_W-1:0] bus_q, bus_d, mux_y;
  logic valid_q, rot;
  if (HOLD_MAX < 2 || HOLD_MAX > 15) begin : g_bad_hold
    $error("HOLD_MAX must be in 2..15");
  end
  assign gnt_a = state_q == ST_GNT_A;
  assign gnt_b = state_q == ST_GNT_B;
  assign sel = gnt_b;
  assign bus_out = bus_q;
  assign bus_valid = valid_q;
  mux2x1 #(.W(BUS_W)) u_mux (.a(data_a), .b(data_b), .s(sel), .y(mux_y));
`ifdef MUX_BUS_ARB_HOLD_LIMIT_EN
  localparam int CW = $clog2(HOLD_MAX);
  logic [CW-1:0] cnt_q, cnt_d;
  logic hold_full;
  assign hold_full = cnt_q == CW'(HOLD_MAX - 1);
  // rotate only when the waiting side is actually requesting
  assign rot = hold_full && (gnt_a ? req_b : req_a);
  assign cnt_d = (state_d != state_q || state_d == ST_IDLE) ? '0 : hold_full ? cnt_q : cnt_q + CW'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  assign rot = 1'b0;
`endif
  always_comb begin
    state_d = ST_IDLE;
    if (state_q == ST_GNT_A) state_d = (req_a && !rot) ? ST_GNT_A : req_b ? ST_GNT_B : ST_IDLE;
    else if (state_q == ST_GNT_B) state_d = (req_b && !rot) ? ST_GNT_B : req_a ? ST_GNT_A : ST_IDLE;
    else state_d = (req_a && (!req_b || last_q)) ? ST_GNT_A : req_b ? ST_GNT_B : ST_IDLE;
    last_d = state_d == ST_GNT_B ? 1'b1 : state_d == ST_GNT_A ? 1'b0 : last_q;
    bus_d = (gnt_a || gnt_b) ? mux_y : bus_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      bus_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      bus_q   <= bus_d;
      valid_q <= gnt_a || gnt_b;
    end
endmodule
